// File: rtl/ccsds123_frame_ctrl.sv
// Frame controller ahead of a CCSDS-123 compressor: cuts the untagged sample stream into frames,
// marks tlast, and waits for the compressor to close each frame. Define CCSDS123_FRAME_CTRL_PERF_EN for perf counters.
module ccsds123_frame_ctrl #(
  parameter int PIPELINES = 3,
  parameter int D         = 16,
  parameter int NX        = 16,
  parameter int NY        = 16,
  parameter int NZ        = 8,
  parameter int CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PIPELINES*D-1:0] s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [PIPELINES*D-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  input  logic                   c_out_tvalid,
  input  logic                   c_out_tlast,
  output logic                   busy,
  output logic                   frame_done,
  output logic [CNT_W-1:0]       frame_count
`ifdef CCSDS123_FRAME_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       run_cycles
`endif
);

  localparam int N      = NX * NY * NZ;
  localparam int B      = (N + PIPELINES - 1) / PIPELINES;
  localparam int R      = N % PIPELINES;
  localparam int BEAT_W = (B > 1) ? $clog2(B) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(B - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               frame_done_q, frame_done_d;
  logic [CNT_W-1:0]   frame_count_q, frame_count_d;
  logic               in_run;
  logic               last_beat;
  logic               accept;

  // Stream path is combinational; rst gates it so nothing leaks out before the first reset edge.
  always_comb begin
    in_run    = (state_q == RUN) && !rst;
    last_beat = in_run && (beat_q == LAST_BEAT);
    m_tvalid  = in_run && s_tvalid;
    s_tready  = in_run && m_tready;
    m_tlast   = last_beat;
    accept    = m_tvalid && m_tready;
    busy      = (state_q != IDLE) && !rst;
    m_tdata   = '0;
    if (in_run) begin
      m_tdata = s_tdata;
      // Lanes past the end of the image on the final beat carry padding, not samples.
      if (last_beat && (R != 0)) begin
        for (int i = R; i < PIPELINES; i++) begin
          m_tdata[i*D +: D] = '0;
        end
      end
    end
  end

  // NOTE: every signal gets its default before the case so no path can leave one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          beat_d  = '0;
        end
      end
      RUN: begin
        if (accept) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            state_d = DRAIN;
            beat_d  = '0;
          end
        end
      end
      DRAIN: begin
        if (c_out_tvalid && c_out_tlast) begin
          state_d       = IDLE;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a final-beat handshake that already happened downstream.
    if (abort) begin
      state_d       = IDLE;
      beat_d        = '0;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
    end
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q       <= state_d;
      beat_q        <= beat_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

`ifdef CCSDS123_FRAME_CTRL_PERF_EN
  logic [CNT_W-1:0] run_cycles_q, run_cycles_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             clear_perf;

  always_comb begin
    clear_perf     = (state_q == IDLE) && start && !abort;
    run_cycles_d   = run_cycles_q;
    stall_cycles_d = stall_cycles_q;
    if (clear_perf) begin
      run_cycles_d   = '0;
      stall_cycles_d = '0;
    end else if (in_run) begin
      if (run_cycles_q != '1) begin
        run_cycles_d = run_cycles_q + CNT_W'(1);
      end
      if (s_tvalid && !m_tready && (stall_cycles_q != '1)) begin
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cycles_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      run_cycles_q   <= run_cycles_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign run_cycles   = run_cycles_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_ccsds123_frame_ctrl.sv
// Directed bench: dut_a frames N=48 (B=16, no padding), dut_b frames N=50 (B=17, two live lanes on the last beat).
module tb_ccsds123_frame_ctrl;
  localparam int P  = 3;
  localparam int D  = 16;
  localparam int W  = P * D;
  localparam int CW = 32;
  localparam int BA = 16;
  localparam int BB = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_start, a_abort, a_s_tvalid, a_m_tready, a_c_v, a_c_l;
  logic [W-1:0]  a_s_tdata, a_m_tdata;
  logic          a_s_tready, a_m_tvalid, a_m_tlast, a_busy, a_done;
  logic [CW-1:0] a_count;
  logic          b_rst, b_start, b_abort, b_s_tvalid, b_m_tready, b_c_v, b_c_l;
  logic [W-1:0]  b_s_tdata, b_m_tdata;
  logic          b_s_tready, b_m_tvalid, b_m_tlast, b_busy, b_done;
  logic [CW-1:0] b_count;
`ifdef CCSDS123_FRAME_CTRL_PERF_EN
  logic [CW-1:0] a_stall, a_run, b_stall, b_run;
`endif

  ccsds123_frame_ctrl #(.PIPELINES(P), .D(D), .NX(4), .NY(4), .NZ(3), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .abort(a_abort),
    .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tready(a_s_tready),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(a_m_tready), .m_tlast(a_m_tlast),
    .c_out_tvalid(a_c_v), .c_out_tlast(a_c_l),
    .busy(a_busy), .frame_done(a_done), .frame_count(a_count)
`ifdef CCSDS123_FRAME_CTRL_PERF_EN
    , .stall_cycles(a_stall), .run_cycles(a_run)
`endif
  );

  ccsds123_frame_ctrl #(.PIPELINES(P), .D(D), .NX(5), .NY(5), .NZ(2), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort),
    .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tlast(b_m_tlast),
    .c_out_tvalid(b_c_v), .c_out_tlast(b_c_l),
    .busy(b_busy), .frame_done(b_done), .frame_count(b_count)
`ifdef CCSDS123_FRAME_CTRL_PERF_EN
    , .stall_cycles(b_stall), .run_cycles(b_run)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] pat(input int b);
    return {16'(16'hA000 + b * 3 + 2), 16'(16'hA000 + b * 3 + 1), 16'(16'hA000 + b * 3)};
  endfunction

  // One cycle: past the edge drive inputs, then stop on the falling edge for sampling.
  task automatic step_a(input logic st, ab, sv, mr, cv, cl, input logic [W-1:0] d);
    @(posedge clk); #1;
    a_start = st; a_abort = ab; a_s_tvalid = sv; a_m_tready = mr;
    a_c_v = cv; a_c_l = cl; a_s_tdata = d;
    @(negedge clk);
  endtask

  task automatic step_b(input logic st, sv, mr, cv, cl, input logic [W-1:0] d);
    @(posedge clk); #1;
    b_start = st; b_s_tvalid = sv; b_m_tready = mr; b_c_v = cv; b_c_l = cl; b_s_tdata = d;
    @(negedge clk);
  endtask

  task automatic check_a(input string tag, input logic mv, sr, last, bz, dn, input logic [CW-1:0] cnt);
    check({tag, "_m_tvalid"}, a_m_tvalid, mv);
    check({tag, "_s_tready"}, a_s_tready, sr);
    check({tag, "_m_tlast"}, a_m_tlast, last);
    check({tag, "_busy"}, a_busy, bz);
    check({tag, "_frame_done"}, a_done, dn);
    check({tag, "_frame_count"}, a_count, cnt);
  endtask

  // Full-rate frame on dut_a; optional stray start/c_out injection and abort at given beat indices.
  task automatic frame_a(input int inject_at, input int abort_at, output int errs);
    errs = 0;
    for (int b = 0; b < BA; b++) begin
      step_a(b == inject_at, b == abort_at, 1'b1, 1'b1, b == inject_at, b == inject_at, pat(b));
      if (a_m_tvalid !== 1'b1 || a_s_tready !== 1'b1) errs++;
      if (a_m_tlast !== (b == BA - 1)) errs++;
      if (a_m_tdata !== pat(b)) errs++;
      if (b == abort_at) break;
    end
  endtask

  typedef struct {
    logic st, ab, sv, mr, cv, cl;
    logic mv, sr, last, bz, dn;
  } vec_t;

  initial begin
    automatic vec_t vecs[10];
    int errs, acc, dut_acc, run_m, stall_m, cyc;
    logic mr;

    a_rst = 1'b1; a_start = 0; a_abort = 0; a_s_tvalid = 0; a_m_tready = 0; a_c_v = 0; a_c_l = 0;
    a_s_tdata = '0;
    b_rst = 1'b1; b_start = 0; b_abort = 0; b_s_tvalid = 0; b_m_tready = 0; b_c_v = 0; b_c_l = 0;
    b_s_tdata = '0;

    // Outputs stay quiet while reset is held, even with upstream and downstream both ready.
    step_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pat(0));
    check_a("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    a_rst = 1'b0;

    //           st ab sv mr cv cl   mv sr last bz dn
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // c_out in IDLE
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // start+abort
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // still IDLE
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // start
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}; // RUN
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // ignored
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // beat 0
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // abort
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // IDLE
    for (int i = 0; i < 10; i++) begin
      step_a(vecs[i].st, vecs[i].ab, vecs[i].sv, vecs[i].mr, vecs[i].cv, vecs[i].cl, pat(i));
      check_a($sformatf("vec%0d", i), vecs[i].mv, vecs[i].sr, vecs[i].last, vecs[i].bz, vecs[i].dn, '0);
    end

    // Full frame with a stray start and c_out_tlast mid-RUN; tlast must still land on beat 15.
    step_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    frame_a(7, -1, errs);
    check("frame48_beats", errs, 0);
    step_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pat(0));
    check_a("drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_a("drain_nolast", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    check_a("drain_clast", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_a("done_pulse", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_a("done_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1);

    // Backpressure: m_tready high one cycle in three, s_tvalid always high.
    step_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    acc = 0; dut_acc = 0; run_m = 0; stall_m = 0; cyc = 0; errs = 0;
    while (acc < BA && cyc < 200) begin
      mr = (cyc % 3 == 0);
      step_a(1'b0, 1'b0, 1'b1, mr, 1'b0, 1'b0, pat(acc));
      if (a_m_tvalid !== 1'b1 || a_s_tready !== mr || a_m_tlast !== (acc == BA - 1)) errs++;
      if (a_m_tvalid === 1'b1 && a_s_tready === 1'b1) dut_acc++;
      run_m++;
      if (!mr) stall_m++;
      if (mr) acc++;
      cyc++;
    end
    check("stall_frame_seq", errs, 0);
    step_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pat(0));
    if (a_m_tvalid === 1'b1 && a_s_tready === 1'b1) dut_acc++;
    check("stall_frame_accepted", dut_acc, BA);
    check("stall_frame_drain_busy", a_busy, 1'b1);
`ifdef CCSDS123_FRAME_CTRL_PERF_EN
    check("run_cycles", a_run, 32'(run_m));
    check("stall_cycles", a_stall, 32'(stall_m));
    check("run_cycles_hand", a_run, 32'd46);
    check("stall_cycles_hand", a_stall, 32'd30);
`endif
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_a("stall_frame_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2);

    // Abort at beat 5, then a clean frame from beat 0.
    step_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    frame_a(-1, 5, errs);
    check("abort5_beats", errs, 0);
    step_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pat(6));
    check_a("abort5_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2);
    step_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    frame_a(-1, -1, errs);
    check("after_abort_frame", errs, 0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_a("after_abort_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3);

    // Abort coinciding with the final handshake returns to IDLE, not DRAIN.
    step_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    frame_a(-1, BA - 1, errs);
    check("abort_last_beats", errs, 0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    check_a("abort_last_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_a("abort_last_nodone", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3);

    // Reset while draining discards the frame and the pending completion.
    step_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    frame_a(-1, -1, errs);
    check("pre_rst_frame", errs, 0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("pre_rst_drain_busy", a_busy, 1'b1);
    a_rst = 1'b1;
    step_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pat(0));
    check_a("rst_in_drain", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    a_rst = 1'b0;
    step_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, pat(0));
    check_a("post_rst_clast", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pat(0));
    check_a("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step_a(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    frame_a(-1, -1, errs);
    check("post_rst_frame", errs, 0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_a("post_rst_done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);

    // dut_b: N=50, last beat keeps lanes 0-1 and zeroes lane 2.
    b_rst = 1'b0;
    step_b(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    errs = 0;
    for (int b = 0; b < BB; b++) begin
      step_b(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, {W{1'b1}});
      if (b_m_tvalid !== 1'b1 || b_m_tlast !== (b == BB - 1)) errs++;
      if (b < BB - 1 && b_m_tdata !== {W{1'b1}}) errs++;
      if (b == BB - 1) check("pad_last_lanes", b_m_tdata, 64'h0000_0000_FFFF_FFFF);
    end
    check("pad_frame_beats", errs, 0);
    step_b(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, {W{1'b1}});
    check("pad_drain_tvalid", b_m_tvalid, 1'b0);
    check("pad_drain_busy", b_busy, 1'b1);
    step_b(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
    step_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("pad_done", b_done, 1'b1);
    check("pad_count", b_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ccsds123_frame_ctrl.md
CCSDS123_FRAME_CTRL -- requirements
Module: ccsds123_frame_ctrl

Interface
REQ-001 SHALL have parameter PIPELINES, default 3: samples per input beat.
REQ-002 SHALL have parameter D, default 16: sample width in bits.
REQ-003 SHALL have parameters NX, NY, NZ, defaults 16, 16, 8: image dimensions; frame size N = NX*NY*NZ samples.
REQ-004 SHALL have parameter CNT_W, default 32: width of frame and performance counters.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1: one-cycle request to begin a frame.
REQ-008 SHALL have port abort, input, 1: force return to IDLE.
REQ-009 SHALL have ports s_tdata (input, PIPELINES*D), s_tvalid (input, 1), s_tready (output, 1): upstream sample stream, no tlast.
REQ-010 SHALL have ports m_tdata (output, PIPELINES*D), m_tvalid (output, 1), m_tready (input, 1), m_tlast (output, 1): stream to the compressor input.
REQ-011 SHALL have ports c_out_tvalid and c_out_tlast, input, 1 each: monitor of the compressor output stream.
REQ-012 SHALL have ports busy (output, 1), frame_done (output, 1, one-cycle pulse) and frame_count (output, CNT_W).

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-014 SHALL move IDLE->RUN on start=1, clearing beat counter and per-frame performance counters.
REQ-015 SHALL ignore start while in RUN or DRAIN.
REQ-016 In RUN, SHALL pass through with zero latency: m_tvalid = s_tvalid, s_tready = m_tready, m_tdata = s_tdata.
REQ-017 Outside RUN, SHALL hold m_tvalid=0 and s_tready=0.
REQ-018 SHALL count accepted beats (m_tvalid & m_tready); frame length B = ceil(N/PIPELINES) beats.
REQ-019 SHALL assert m_tlast combinationally exactly on beat index B-1, and on no other beat.
REQ-020 On the last beat, if N mod PIPELINES = r != 0, SHALL force lanes r..PIPELINES-1 of m_tdata (lane i = bits i*D +: D) to zero.
REQ-021 SHALL move RUN->DRAIN on acceptance of the last beat.
REQ-022 In DRAIN, SHALL move to IDLE on c_out_tvalid=1 with c_out_tlast=1, pulse frame_done for one cycle, and increment frame_count.
REQ-023 SHALL wrap frame_count modulo 2^CNT_W.
REQ-024 SHALL assert busy in RUN and DRAIN.
REQ-025 SHALL ignore c_out_tvalid & c_out_tlast seen in IDLE or RUN.
REQ-026 On abort=1 in any state, SHALL go to IDLE next cycle, with no frame_done and no frame_count change.
REQ-027 When abort is asserted on the final-beat handshake cycle, the beat SHALL be accepted, and abort SHALL take priority over the transition to DRAIN.
REQ-028 When start and abort are asserted together in IDLE, SHALL remain in IDLE.

Reset
REQ-029 On rst=1 at a clock edge, SHALL enter IDLE, clear beat counter, frame_count and performance counters, and drive frame_done=0.
REQ-030 During and after reset, SHALL drive m_tvalid=0, s_tready=0, m_tlast=0 and busy=0.
REQ-031 Reset mid-frame SHALL discard all progress; the next frame SHALL begin at beat 0.

Configuration
REQ-032 SHALL support macro CCSDS123_FRAME_CTRL_PERF_EN.
REQ-033 When CCSDS123_FRAME_CTRL_PERF_EN is defined, SHALL add outputs stall_cycles and run_cycles (each CNT_W).
REQ-034 With the macro defined, run_cycles SHALL count cycles in RUN, and stall_cycles SHALL count RUN cycles with s_tvalid=1 and m_tready=0.
REQ-035 With the macro defined, both counters SHALL be cleared on the IDLE->RUN transition, held in IDLE and DRAIN, and saturate at all-ones.
REQ-036 When CCSDS123_FRAME_CTRL_PERF_EN is not defined, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Bench SHALL cover: NX=NY=4, NZ=3, PIPELINES=3 (N=48, B=16), start, continuous valid/ready -> m_tlast only on beat 15, DRAIN, then frame_done one cycle after c_out_tlast and frame_count=1.
REQ-038 Bench SHALL cover: N=50, PIPELINES=3 (B=17, r=2), last input 0xFFFF in all lanes -> beat 16 lane 2 = 0, lanes 0-1 = 0xFFFF.
REQ-039 Bench SHALL cover: m_tready toggled 1/3 duty over a full frame with PERF_EN defined -> exactly B beats accepted, stall_cycles = cycles with s_tvalid & !m_tready, and run_cycles = total RUN cycles.
REQ-040 Bench SHALL cover: abort at beat 5 -> IDLE next cycle, frame_count unchanged, and a new start gives m_tlast at beat B-1 again.
REQ-041 Bench SHALL cover: rst during DRAIN, then c_out_tlast -> no frame_done, frame_count=0, and s_tready=0 until the next start.
REQ-042 Bench SHALL cover: start pulsed during RUN, plus c_out_tlast in IDLE -> both ignored, with no state change.
